// File: rtl/sub_bytes_iter_if.sv
// sub_bytes_iter_if: handshake bundle for the iterative SubBytes engine.
//   in_valid/in_ready/in_state/in_inv     : request channel (producer -> engine)
//   out_valid/out_ready/out_state         : result channel  (engine -> consumer)
// modport slave is the engine side; modport master is the producer/consumer side.
interface sub_bytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: AES SubBytes / InvSubBytes over a 128-bit state, LANES bytes
// per clock, so a block takes 16/LANES RUN cycles.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : sub_bytes_iter_if.slave (request and result handshakes)
//   busy   : high while a block is in RUN or waiting in DONE
//
// state | meaning
// IDLE  | in_ready=1, waiting for a block
// RUN   | substituting LANES bytes per edge, cnt selects the byte group
// DONE  | out_valid=1, result held until out_ready
module sub_bytes_iter #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sub_bytes_iter_if.slave  bus,
  output logic             busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Inverse table is derived by scattering the forward table, so it is the
  // exact inverse by construction. Tied off when the inverse is not built.
  logic [7:0] inv_tab [256];

  generate
    if (INV_EN != 0) begin : g_inv
      for (genvar i = 0; i < 256; i++) begin : g_ent
        assign inv_tab[SBOX[i]] = 8'(i);
      end
    end else begin : g_no_inv
      for (genvar i = 0; i < 256; i++) begin : g_ent
        assign inv_tab[i] = 8'h00;
      end
    end
  endgenerate

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [127:0]    work, work_nxt;
  logic            mode;
  logic            cnt_last;
  logic [6:0]      off;
  logic [7:0]      lane_in;

  assign cnt_last = (cnt == CW'(N - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (cnt_last)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Substitute the byte group selected by cnt; all other bytes pass through.
  always_comb begin
    work_nxt = work;
    off      = 7'd0;
    lane_in  = 8'h00;
    for (int l = 0; l < LANES; l++) begin
      off     = 7'((int'(cnt) * LANES + l) * 8);
      lane_in = work[off +: 8];
      work_nxt[off +: 8] = mode ? inv_tab[lane_in] : SBOX[lane_in];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work <= bus.in_state;
            mode <= (INV_EN != 0) ? bus.in_inv : 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          work <= work_nxt;
          cnt  <= cnt_last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_state = work;
  assign busy          = (state != IDLE);

endmodule
